// File: rtl/cgra_conf_receiver.sv
// CGRA configuration receiver: snoops a daisy-chained config bus,
// collects NWORDS payload slices for this node and commits them atomically.
module cgra_conf_receiver #(
  parameter logic [7:0] PE_ID  = 8'd1,
  parameter int         NWORDS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            conf_in_bus,
  output logic [63:0]            conf_out_bus,
  output logic [48*NWORDS-1:0]   conf,
  output logic                   conf_valid,
  output logic                   configured,
  output logic                   err
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ACTIVE  = 2'd2,
    REFILL  = 2'd3
  } state_t;

  localparam logic [2:0] NW = 3'(NWORDS);

  state_t                 state, state_n;
  logic [NWORDS-1:0]      recv_mask, mask_n, sel;
  logic [48*NWORDS-1:0]   shadow, shadow_n;

  logic        present, hit, bcast, take, in_rng, cap, oob, commit;
  logic [7:0]  id;
  logic [1:0]  idx;
  logic [47:0] payload;

  // Reserved bits only participate in the idle test, never in matching.
  assign present = |conf_in_bus;
  assign id      = conf_in_bus[7:0];
  assign idx     = conf_in_bus[9:8];
  assign payload = conf_in_bus[63:16];

  assign hit    = present && (id != 8'h00) && (id == PE_ID);
  assign bcast  = present && (id == 8'hFF);
  assign take   = hit || bcast;
  assign in_rng = {1'b0, idx} < NW;
  assign cap    = take && in_rng;
  assign oob    = take && !in_rng;

  always_comb begin
    sel      = '0;
    shadow_n = shadow;
    for (int k = 0; k < NWORDS; k++) begin
      sel[k] = cap && (idx == 2'(k));
      if (sel[k]) shadow_n[48*k +: 48] = payload;
    end
    mask_n = recv_mask | sel;
  end

  assign commit = cap && (&mask_n);

  always_comb begin
    state_n = state;
    if (commit) begin
      state_n = ACTIVE;
    end else if (cap) begin
      unique case (state)
        EMPTY:   state_n = FILLING;
        ACTIVE:  state_n = REFILL;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      recv_mask    <= '0;
      shadow       <= '0;
      conf         <= '0;
      conf_valid   <= 1'b0;
      conf_out_bus <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      shadow       <= shadow_n;
      recv_mask    <= commit ? '0 : mask_n;
      conf_valid   <= commit;
      conf_out_bus <= hit ? 64'd0 : conf_in_bus;
      if (commit) conf <= shadow_n;
      if (oob)    err  <= 1'b1;
    end
  end

  assign configured = (state == ACTIVE) || (state == REFILL);

endmodule
